// File: rtl/pipeline_hazard_ctrl.sv
// Hazard-control unit for the 5-stage pipeline. It detects load-use and
// register-dependent CBZ/CBNZ hazards that forwarding cannot cover, stalls the
// front end, flushes IF on taken branches, and keeps saturating stall/flush
// counters for performance debug.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       readRegA_ID,
  input  logic [4:0]       readRegB_ID,
  input  logic             useB_ID,
  input  logic             isCBZ_ID,
  input  logic             branchTaken_ID,
  input  logic [4:0]       writeReg_EX,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [4:0]       writeReg_MEM,
  input  logic             MemRead_MEM,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             bubble_ID,
  output logic             flush_IF,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [4:0]       XZR     = 5'd31;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state, nextState;
  logic       rem, remNext;
  logic [1:0] hazLen;

  logic aHitEx, bExamined, bHitEx, bHitMem;
  logic loadUse, cbzAfterAlu, cbzAfterLoadEx, cbzAfterLoadMem;

  // Source-match terms; XZR never produces a dependence.
  always_comb begin
    aHitEx          = (readRegA_ID != XZR) && (writeReg_EX == readRegA_ID);
    bExamined       = useB_ID || isCBZ_ID;
    bHitEx          = (readRegB_ID != XZR) && (writeReg_EX == readRegB_ID);
    bHitMem         = (readRegB_ID != XZR) && (writeReg_MEM == readRegB_ID);
    loadUse         = MemRead_EX && (aHitEx || (bExamined && bHitEx));
    cbzAfterAlu     = isCBZ_ID && RegWrite_EX && !MemRead_EX && bHitEx;
    cbzAfterLoadEx  = isCBZ_ID && MemRead_EX && bHitEx;
    cbzAfterLoadMem = isCBZ_ID && MemRead_MEM && bHitMem;
  end

  // Hazard length: the longest requirement among all detected conditions.
  always_comb begin
    hazLen = 2'd0;
    if (cbzAfterLoadEx)
      hazLen = 2'd2;
    else if (loadUse || cbzAfterAlu || cbzAfterLoadMem)
      hazLen = 2'd1;
  end

  // State and remaining-stall register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      rem   <= 1'b0;
    end else begin
      state <= nextState;
      rem   <= remNext;
    end
  end

  // Next-state and pipeline-control outputs; run values are forced during reset.
  always_comb begin
    nextState = state;
    remNext   = rem;
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    bubble_ID = 1'b0;
    flush_IF  = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          if (hazLen != 2'd0) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            bubble_ID = 1'b1;
            if (hazLen == 2'd2) begin
              remNext   = 1'b1;
              nextState = HOLD;
            end
          end else begin
            flush_IF = branchTaken_ID;
          end
        end
        HOLD: begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          bubble_ID = 1'b1;
          remNext   = rem - 1'b1;
          nextState = (remNext == 1'b0) ? RUN : HOLD;
        end
        default: nextState = RUN;
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (bubble_ID && (stallCount != '1))
        stallCount <= stallCount + CNT_ONE;
      if (flush_IF && (flushCount != '1))
        flushCount <= flushCount + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic,
// checked against a cycle-level reference model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    readRegA_ID, readRegB_ID, writeReg_EX, writeReg_MEM;
  logic          useB_ID, isCBZ_ID, branchTaken_ID;
  logic          RegWrite_EX, MemRead_EX, MemRead_MEM;
  logic          PCWrite, IFIDWrite, bubble_ID, flush_IF;
  logic [CW-1:0] stallCount, flushCount;

  int unsigned totalChecks = 0;
  int unsigned badChecks   = 0;

  // Reference model state: stall cycles still owed and event totals.
  int unsigned holdLeft    = 0;
  longint      stallEvents = 0;
  longint      flushEvents = 0;

  pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .readRegA_ID    (readRegA_ID),
    .readRegB_ID    (readRegB_ID),
    .useB_ID        (useB_ID),
    .isCBZ_ID       (isCBZ_ID),
    .branchTaken_ID (branchTaken_ID),
    .writeReg_EX    (writeReg_EX),
    .RegWrite_EX    (RegWrite_EX),
    .MemRead_EX     (MemRead_EX),
    .writeReg_MEM   (writeReg_MEM),
    .MemRead_MEM    (MemRead_MEM),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .bubble_ID      (bubble_ID),
    .flush_IF       (flush_IF),
    .stallCount     (stallCount),
    .flushCount     (flushCount)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] satCnt(input longint x);
    longint maxv;
    maxv = (64'd1 << CW) - 1;
    return (x > maxv) ? 32'(maxv) : 32'(x);
  endfunction

  // Required stall length from the current ID/EX/MEM contents.
  function automatic int reqStall();
    int  n;
    bit  bExam;
    n     = 0;
    bExam = useB_ID || isCBZ_ID;
    if (MemRead_EX && ((readRegA_ID != 31 && readRegA_ID == writeReg_EX) ||
                       (bExam && readRegB_ID != 31 && readRegB_ID == writeReg_EX)))
      n = 1;
    if (isCBZ_ID && readRegB_ID != 31) begin
      if (RegWrite_EX && !MemRead_EX && writeReg_EX == readRegB_ID && n < 1) n = 1;
      if (MemRead_MEM && writeReg_MEM == readRegB_ID && n < 1) n = 1;
      if (MemRead_EX && writeReg_EX == readRegB_ID) n = 2;
    end
    return n;
  endfunction

  task automatic setIdle();
    readRegA_ID = 5'd0; readRegB_ID = 5'd0; useB_ID = 1'b0; isCBZ_ID = 1'b0;
    branchTaken_ID = 1'b0; writeReg_EX = 5'd0; RegWrite_EX = 1'b0;
    MemRead_EX = 1'b0; writeReg_MEM = 5'd0; MemRead_MEM = 1'b0;
  endtask

  // Called at a falling edge after inputs are set: check, advance model, move to next falling edge.
  task automatic step(input string tag);
    int n;
    bit expStall, expFlush;
    #1;
    n        = reqStall();
    expStall = (holdLeft > 0) || (n > 0);
    expFlush = !expStall && branchTaken_ID;
    checkVal({tag, ".PCWrite"},   PCWrite,    !expStall);
    checkVal({tag, ".IFIDWrite"}, IFIDWrite,  !expStall);
    checkVal({tag, ".bubble"},    bubble_ID,  expStall);
    checkVal({tag, ".flush"},     flush_IF,   expFlush);
    checkVal({tag, ".stallCnt"},  stallCount, satCnt(stallEvents));
    checkVal({tag, ".flushCnt"},  flushCount, satCnt(flushEvents));
    if (holdLeft > 0)  holdLeft--;
    else if (n > 0)    holdLeft = n - 1;
    if (expStall) stallEvents++;
    if (expFlush) flushEvents++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    setIdle();
    reset = 1'b1;
    #1;
    checkVal("rst.PCWrite",  PCWrite,    1);
    checkVal("rst.bubble",   bubble_ID,  0);
    checkVal("rst.stallCnt", stallCount, 0);
    checkVal("rst.flushCnt", flushCount, 0);
    @(negedge clk);
    reset = 1'b0;
    holdLeft = 0; stallEvents = 0; flushEvents = 0;
  endtask

  function automatic logic [4:0] pickReg();
    logic [4:0] regs [5];
    regs = '{5'd0, 5'd5, 5'd7, 5'd9, 5'd31};
    return regs[$urandom_range(0, 4)];
  endfunction

  initial begin
    setIdle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkVal("init.PCWrite",   PCWrite,    1);
    checkVal("init.IFIDWrite", IFIDWrite,  1);
    checkVal("init.bubble",    bubble_ID,  0);
    checkVal("init.flush",     flush_IF,   0);
    checkVal("init.stallCnt",  stallCount, 0);
    checkVal("init.flushCnt",  flushCount, 0);
    reset = 1'b0;

    // Load-use on source A.
    MemRead_EX = 1'b1; writeReg_EX = 5'd5; readRegA_ID = 5'd5;
    step("loadUse");
    setIdle();
    step("loadUseRel");
    checkVal("loadUse.total", stallCount, 1);

    // XZR never stalls.
    doReset();
    MemRead_EX = 1'b1; writeReg_EX = 5'd31; readRegA_ID = 5'd31;
    step("xzr");
    checkVal("xzr.stallCnt", stallCount, 0);

    // Load then CBZ: two-cycle stall even after inputs go idle.
    doReset();
    isCBZ_ID = 1'b1; readRegB_ID = 5'd7; MemRead_EX = 1'b1; writeReg_EX = 5'd7;
    step("ldCbz1");
    setIdle();
    step("ldCbz2");
    step("ldCbz3");
    checkVal("ldCbz.total", stallCount, 2);

    // Branch flush, then branch masked by a load-use stall.
    doReset();
    branchTaken_ID = 1'b1;
    step("br");
    setIdle();
    step("brRel");
    checkVal("br.total", flushCount, 1);
    branchTaken_ID = 1'b1; MemRead_EX = 1'b1; writeReg_EX = 5'd5; readRegA_ID = 5'd5;
    step("brStall");
    setIdle();
    step("brStallRel");

    // Unused B does not create a hazard.
    doReset();
    readRegB_ID = 5'd9; MemRead_EX = 1'b1; writeReg_EX = 5'd9; readRegA_ID = 5'd1;
    step("unusedB");

    // Reset during the second cycle of a load-then-CBZ stall.
    doReset();
    isCBZ_ID = 1'b1; readRegB_ID = 5'd7; MemRead_EX = 1'b1; writeReg_EX = 5'd7;
    step("rstHold1");
    setIdle();
    #1;
    checkVal("rstHold.inHold", bubble_ID, 1);
    reset = 1'b1;
    #1;
    checkVal("rstHold.PCWrite",  PCWrite,    1);
    checkVal("rstHold.IFIDWrite", IFIDWrite, 1);
    checkVal("rstHold.bubble",   bubble_ID,  0);
    checkVal("rstHold.stallCnt", stallCount, 0);
    checkVal("rstHold.flushCnt", flushCount, 0);
    @(negedge clk);
    reset = 1'b0;
    holdLeft = 0; stallEvents = 0; flushEvents = 0;
    step("rstHoldAfter");

    // Randomized traffic; long enough to saturate the narrow counters.
    for (int i = 0; i < 2000; i++) begin
      readRegA_ID    = pickReg();
      readRegB_ID    = pickReg();
      writeReg_EX    = pickReg();
      writeReg_MEM   = pickReg();
      useB_ID        = 1'($urandom_range(0, 1));
      isCBZ_ID       = 1'($urandom_range(0, 1));
      branchTaken_ID = 1'($urandom_range(0, 1));
      RegWrite_EX    = 1'($urandom_range(0, 1));
      MemRead_EX     = 1'($urandom_range(0, 1));
      MemRead_MEM    = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
